// File: rtl/qed_regfile.sv
// Register file split into original/duplicate halves with SQED commit tracking; QED_FULL_CHECK_EN compares every pair, else only (1, H+1).
// Latency: writes land on the next edge (core read ports bypass same-cycle core writes); qed_err_o rises one edge after a mismatch.
// Backpressure: none; core write wins over a same-cycle debug write, which is dropped.
module qed_regfile #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int CNT_W = 16,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we_i,
   input  logic [AW-1:0]        waddr_i,
   input  logic [XLEN-1:0]      wdata_i,
   input  logic                 qed_vld_i,
   input  logic                 dbg_we_i,
   input  logic [AW-1:0]        dbg_addr_i,
   input  logic [XLEN-1:0]      dbg_wdata_i,
   output logic [XLEN-1:0]      dbg_rdata_o,
   input  logic [NRD*AW-1:0]    raddr_i,
   output logic [NRD*XLEN-1:0]  rdata_o,
   output logic [CNT_W-1:0]     orig_cnt_o,
   output logic [CNT_W-1:0]     dup_cnt_o,
   output logic                 qed_ready_o,
   output logic [1:0]           qed_state_o,
   output logic                 qed_err_o
);

   localparam int H = NREGS / 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_TRACK = 2'd1,
      S_FAIL  = 2'd2,
      S_OVF   = 2'd3
   } state_t;

   logic [XLEN-1:0]  regs [NREGS];
   state_t           state;
   logic             err_q;
   logic [CNT_W-1:0] orig_cnt, dup_cnt;

   logic core_wr, dbg_wr, commit, dup_commit, at_max;
   logic qed_ready, pair_diff, mismatch;

   function automatic logic is_zero_addr(input logic [AW-1:0] a);
      return (a == '0) || (a == AW'(H));
   endfunction

   assign core_wr    = we_i & ~is_zero_addr(waddr_i);
   assign dbg_wr     = dbg_we_i & ~is_zero_addr(dbg_addr_i) & ~core_wr;
   assign commit     = core_wr & qed_vld_i;
   assign dup_commit = (waddr_i >= AW'(H));
   assign at_max     = dup_commit ? (dup_cnt == {CNT_W{1'b1}}) : (orig_cnt == {CNT_W{1'b1}});

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (core_wr) begin
         regs[waddr_i] <= wdata_i;
      end else if (dbg_wr) begin
         regs[dbg_addr_i] <= dbg_wdata_i;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] a;
      assign a = raddr_i[k*AW +: AW];
      assign rdata_o[k*XLEN +: XLEN] = is_zero_addr(a)          ? '0      :
                                       (we_i && a == waddr_i)   ? wdata_i :
                                                                  regs[a];
   end

   assign dbg_rdata_o = regs[dbg_addr_i];

`ifdef QED_FULL_CHECK_EN
   always_comb begin
      pair_diff = 1'b0;
      for (int i = 1; i < H; i++) begin
         if (regs[i] != regs[i+H]) pair_diff = 1'b1;
      end
   end
`else
   assign pair_diff = (regs[1] != regs[H+1]);
`endif

   assign qed_ready = (orig_cnt == dup_cnt) & (orig_cnt != '0) & (state != S_OVF);
   assign mismatch  = qed_ready & pair_diff;

   // Counters stop at max: in TRACK that is the OVF transition, in FAIL plain saturation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         err_q    <= 1'b0;
         orig_cnt <= '0;
         dup_cnt  <= '0;
      end else begin
         if (commit && !at_max && state != S_OVF) begin
            if (dup_commit) dup_cnt  <= dup_cnt + CNT_W'(1);
            else            orig_cnt <= orig_cnt + CNT_W'(1);
         end
         case (state)
            S_IDLE: if (commit) state <= S_TRACK;
            S_TRACK: begin
               if (mismatch) begin
                  state <= S_FAIL;
                  err_q <= 1'b1;
               end else if (commit && at_max) begin
                  state <= S_OVF;
               end
            end
            default: ;
         endcase
      end
   end

   assign orig_cnt_o  = orig_cnt;
   assign dup_cnt_o   = dup_cnt;
   assign qed_ready_o = qed_ready;
   assign qed_state_o = state;
   assign qed_err_o   = err_q;

endmodule

// File: doc/qed_regfile.md
# qed_regfile

Parametrised general-purpose register file with built-in SQED self-consistency tracking. It replaces the fixed 32×32 core register file: storage is split into an original half and a duplicate half. It counts committed writes to each half and, whenever both halves have committed the same nonzero number of instructions, compares original and duplicate registers. Mismatches are reported through a sticky error state rather than a formal-only assertion, so the check also works in simulation and emulation. Sits between the EX write-back stage and the ID read stage; the debug (JTAG) port has the lower write priority.

## Interface
Parameters:
- XLEN, 32, register width in bits
- NREGS, 32, total registers; even, ≥4; H = NREGS/2; original = 0..H-1, duplicate = H..NREGS-1
- NRD, 2, number of ID read ports
- CNT_W, 16, commit counter width
- AW, $clog2(NREGS), address width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- we_i  in  1  core write enable
- waddr_i  in  AW  core write address
- wdata_i  in  XLEN  core write data
- qed_vld_i  in  1  core write is a QED-valid commit
- dbg_we_i  in  1  debug write enable
- dbg_addr_i  in  AW  debug read/write address
- dbg_wdata_i  in  XLEN  debug write data
- dbg_rdata_o  out  XLEN  debug read data (combinational)
- raddr_i  in  NRD*AW  read addresses, port k at [k*AW +: AW]
- rdata_o  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN] (combinational)
- orig_cnt_o  out  CNT_W  original-half commit count
- dup_cnt_o  out  CNT_W  duplicate-half commit count
- qed_ready_o  out  1  counts equal and nonzero, not overflowed
- qed_state_o  out  2  0 IDLE, 1 TRACK, 2 FAIL, 3 OVF
- qed_err_o  out  1  state == FAIL

## Operation
- Zero registers: indices 0 and H read as 0 and ignore all writes.
- Writes: core write (we_i, waddr_i not in {0,H}) has priority. A debug write in the same cycle is dropped, even when it targets a different address.
- Core read port k: if addr is 0 or H, the port returns 0. Otherwise, if addr == waddr_i and we_i, it bypasses to wdata_i. Otherwise it returns the stored value. dbg_rdata_o has no bypass.
- Commit: we_i & qed_vld_i & waddr_i not in {0,H}. An original commit has waddr_i < H; a duplicate commit has waddr_i ≥ H. Each commit increments its own counter by 1.
- qed_ready_o = (orig_cnt == dup_cnt) & (orig_cnt != 0) & (state != OVF).
- Mismatch: qed_ready_o is high and any checked pair regs[i] != regs[i+H]. The checked set is defined under Configuration.
- FSM transitions:
  - IDLE → TRACK on first commit.
  - TRACK → FAIL on mismatch.
  - TRACK → OVF when either counter would pass 2^CNT_W−1. Counters then hold, and checking stops.
  - FAIL and OVF are sticky until rst.
  - FAIL has priority over OVF in the same cycle.
- Counters keep counting in FAIL, saturating at max.

## Timing
- Reset values: all registers 0, both counters 0, state IDLE. So qed_ready_o=0, qed_err_o=0, qed_state_o=0, and rdata_o/dbg_rdata_o read 0.
- rst applied mid-operation clears everything on that edge; writes in that cycle are discarded.
- Write latency: stored on the next edge; visible the same cycle only through the core-port bypass.
- Counters update on the same edge as the commit's register write. qed_ready_o and the mismatch compare therefore use settled contents in the following cycle.
- Mismatch is combinational on registered state; qed_err_o rises on the next edge (1-cycle latency).
- Simultaneous original and duplicate commits are impossible (one write port).

## Configuration
- QED_FULL_CHECK_EN defined: all pairs i = 1..H-1 are compared.
- Not defined: only pair (1, H+1) is compared. This gives lower area and covers the legacy single-register check.

## Test plan
- Reset, then read all ports at addresses 0, 1, H → all 0, state IDLE. Write x0 and xH with 0xFFFF_FFFF → both still read 0.
- Core write x5 = 0xA5A5_0001 with raddr_i port0 = 5 in the same cycle → rdata port0 = 0xA5A5_0001 immediately. dbg_rdata at addr 5 shows the value only from the next cycle.
- Same-cycle core write x3 = 1 and debug write x4 = 2 → x3 = 1, x4 unchanged (0).
- Commit x1 = 7 (qed_vld), then x(H+1) = 7 → counts 1/1, qed_ready_o = 1, state TRACK, qed_err_o stays 0.
- Commit x2 = 9 and x(H+2) = 8 with QED_FULL_CHECK_EN → qed_err_o = 1 one cycle after counts equalise, and it stays 1 through later commits. Without the macro → no error. Then rst → state IDLE, counts 0.
- CNT_W = 2: commit 4 original writes → state OVF on the 4th, orig_cnt holds 3, and qed_ready_o stays 0 after 3 duplicate commits.
